// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and event type for the PS/2 key front end
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and a combinational head
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_en;
  logic             rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_key_frontend.sv
// rtl/ps2_key_frontend.sv - PS/2 frame receiver, prefix assembler and key event FIFO
module ps2_key_frontend
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [9:0]             shift_q, shift_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_q, ext_d;
  logic                   rel_q, rel_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;

  logic       clk_s;
  logic       dat_s;
  logic       ps2_fall;
  logic       frame_ok;
  logic [7:0] rx_byte;
  logic       push;
  ps2_event_t push_data;
  logic       pop;
  logic       full;
  logic       empty;
  ps2_event_t head;

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign ps2_fall = clk_prev_q && !clk_s;
  assign pop      = key_ready && !empty;

  // Shift register fills from the top, so after ten bits [0]=start, [8:1]=data, [9]=parity.
  assign rx_byte  = shift_q[8:1];
  assign frame_ok = !shift_q[0] && dat_s && (^shift_q[9:1]);

  always_comb begin
    clk_sync_d  = (clk_sync_q << 1) | SYNC_STAGES'(ps2_clk);
    dat_sync_d  = (dat_sync_q << 1) | SYNC_STAGES'(ps2_data);
    clk_prev_d  = clk_s;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    rel_d       = rel_q;
    frame_err_d = 1'b0;
    overflow_d  = 1'b0;
    push        = 1'b0;
    push_data   = '{ext: ext_q, rel: rel_q, code: rx_byte};

    if (ps2_fall) begin
      tmo_d = '0;
      if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
        bit_cnt_d = '0;
        if (!frame_ok) begin
          frame_err_d = 1'b1;
          ext_d       = 1'b0;
          rel_d       = 1'b0;
        end else if (rx_byte == PS2_EXT_PREFIX) begin
          ext_d = 1'b1;
        end else if (rx_byte == PS2_BRK_PREFIX) begin
          rel_d = 1'b1;
        end else begin
          ext_d = 1'b0;
          rel_d = 1'b0;
          if (full && !pop) begin
            overflow_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {dat_s, shift_q[9:1]};
      end
    end else if (bit_cnt_q != '0) begin
      // A stalled frame is abandoned quietly; prefix flags survive the restart.
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_d     = '0;
        bit_cnt_d = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= '0;
      dat_sync_q  <= '0;
      clk_prev_q  <= 1'b0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(ps2_event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head     (head)
  );

  assign key_valid   = !empty;
  assign key_code    = head.code;
  assign key_ext     = head.ext;
  assign key_release = head.rel;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_ps2_key_frontend.sv
// tb/tb_ps2_key_frontend.sv - randomized self-checking bench for ps2_key_frontend
module tb_ps2_key_frontend;

  localparam int DEPTH = 8;
  localparam int TMO   = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;
  logic       frame_err;

  logic [9:0] obs_q[$];
  logic [9:0] exp_q[$];
  int         err_seen, ovf_seen, exp_err, exp_ovf;
  logic       m_ext, m_rel;
  int         n_vec = 0;
  int         n_bad = 0;
  int         half  = 20;

  always #5 clk = ~clk;

  ps2_key_frontend #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_release(key_release),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid && key_ready) obs_q.push_back({key_ext, key_release, key_code});
      if (frame_err) err_seen++;
      if (overflow) ovf_seen++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    err_seen = 0;
    ovf_seen = 0;
    exp_err  = 0;
    exp_ovf  = 0;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic bad);
    return {1'b1, ~(^d) ^ bad, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      cycles(half);
      ps2_clk = 1'b0;
      cycles(half);
      ps2_clk = 1'b1;
    end
  endtask

  // Reference: prefixes accumulate, any other good byte is an event, bad frames clear prefixes.
  task automatic model(input logic [7:0] d, input logic bad, input logic hold);
    if (bad) begin
      exp_err++;
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      if (hold && exp_q.size() >= DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_rel, d});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic bad, input logic hold);
    model(d, bad, hold);
    send_bits(frame(d, bad), 11);
    cycles(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; key_ready = 1'b0;
    m_ext = 1'b0; m_rel = 1'b0;
    cycles(3);
    n_vec++;
    if ({key_valid, key_code, key_ext, key_release, overflow, frame_err} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b required 0", {key_valid, key_code, key_ext, key_release, overflow, frame_err});
    end
    rst = 1'b0;
    cycles(10);
    n_vec++;
    if ({key_valid, overflow, frame_err} !== 3'd0) begin
      n_bad++;
      $display("FAIL post_reset_idle: got %b required 000", {key_valid, overflow, frame_err});
    end
  endtask

  task automatic test_basic();
    clear_obs();
    key_ready = 1'b1;
    send(8'h1C, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h1C, 1'b0, 1'b0);
    send(8'hE0, 1'b0, 1'b0);
    send(8'hF0, 1'b0, 1'b0);
    send(8'h75, 1'b0, 1'b0);
    cycles(10);
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL basic_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL basic_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_parity();
    clear_obs();
    key_ready = 1'b1;
    send(8'h1C, 1'b1, 1'b0);
    send(8'h32, 1'b0, 1'b0);
    cycles(10);
    n_vec++;
    if (err_seen !== exp_err) begin
      n_bad++;
      $display("FAIL parity_err_pulses: got %0d required %0d", err_seen, exp_err);
    end
    n_vec++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL parity_followup: got %0d events head %h required 1 event %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    key_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0, 1'b1);
    n_vec++;
    if (ovf_seen !== 0 || key_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_early: got ovf=%0d valid=%b required ovf=0 valid=1", ovf_seen, key_valid);
    end
    send(8'h09, 1'b0, 1'b1);
    n_vec++;
    if (ovf_seen !== exp_ovf) begin
      n_bad++;
      $display("FAIL overflow_pulses: got %0d required %0d", ovf_seen, exp_ovf);
    end
    key_ready = 1'b1;
    cycles(20);
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL drain_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL drain_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    key_ready = 1'b1;
    send_bits(frame(8'h55, 1'b0), 5);
    ps2_data = 1'b1;
    cycles(2 * TMO);
    send(8'h2A, 1'b0, 1'b0);
    cycles(10);
    n_vec++;
    if (err_seen !== 0) begin
      n_bad++;
      $display("FAIL timeout_err: got %0d pulses required 0", err_seen);
    end
    n_vec++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL timeout_event: got %0d events head %h required 1 event %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_rst_midframe();
    clear_obs();
    key_ready = 1'b0;
    send(8'h11, 1'b0, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h13, 1'b0, 1'b0);
    n_vec++;
    if (key_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL queued_valid: got %b required 1", key_valid);
    end
    send_bits(frame(8'h44, 1'b0), 5);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (key_valid !== 1'b0 || key_code !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset: got valid=%b code=%h required 0/00", key_valid, key_code);
    end
    ps2_data = 1'b1;
    m_ext = 1'b0; m_rel = 1'b0;
    cycles(3);
    rst = 1'b0;
    clear_obs();
    key_ready = 1'b1;
    cycles(10);
    send(8'h3B, 1'b0, 1'b0);
    cycles(10);
    n_vec++;
    if (obs_q.size() !== 1 || obs_q[0] !== exp_q[0]) begin
      n_bad++;
      $display("FAIL post_reset_event: got %0d events head %h required 1 event %h",
               obs_q.size(), obs_q.size() > 0 ? obs_q[0] : 10'h0, exp_q[0]);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic       bad;
    int         r;
    clear_obs();
    key_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      d = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      if (n == 29) begin
        d   = 8'h11;
        bad = 1'b0;
      end
      half = $urandom_range(12, 25);
      send(d, bad, 1'b0);
    end
    half = 20;
    cycles(10);
    n_vec++;
    if (err_seen !== exp_err) begin
      n_bad++;
      $display("FAIL random_err_pulses: got %0d required %0d", err_seen, exp_err);
    end
    n_vec++;
    if (obs_q.size() !== exp_q.size()) begin
      n_bad++;
      $display("FAIL random_count: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL random_event%0d: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_overflow();
    test_timeout();
    test_rst_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_frontend.md
# ps2_key_frontend

- Receives raw PS/2 keyboard frames and decodes them into whole key events.
- Each event is a scancode plus `ext` (0xE0 prefix seen) and `release` (0xF0 prefix seen).
- Events are buffered in a small FIFO and presented on a valid/ready port.
- Sits directly upstream of the keyed lookup mux: `key_code` is the mux key, and the mux produces ASCII / display codes.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `ps2_clk` and `ps2_data`.
- `TIMEOUT_CYCLES`, 50000: idle `clk` cycles mid-frame before the frame is abandoned.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  system clock.
  - `rst`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `key_code`  out  8  scancode at FIFO head.
- `key_ext`  out  1  head event was prefixed by 0xE0.
- `key_release`  out  1  head event was prefixed by 0xF0.
- `key_valid`  out  1  FIFO non-empty.
- `key_ready`  in  1  consumer accepts head this cycle.
- `overflow`  out  1  one-cycle pulse: event dropped because FIFO full.
- `frame_err`  out  1  one-cycle pulse: bad start, stop or parity.

## Operation
- `ps2_clk` and `ps2_data` each pass through `SYNC_STAGES` flops.
- Falling edge = synchronized clock was 1 last cycle and is 0 this cycle. `ps2_data` is sampled on that cycle.
- Frame is 11 bits: start (0), d0..d7 LSB first, odd parity, stop (1). A 4-bit counter runs 0..10.
- At bit 10, the frame is valid iff start==0, stop==1, and XOR(d7..d0, parity)==1.
  - Invalid frame: pulse `frame_err`, discard the byte, clear the `ext`/`release` flags. Counter returns to 0 either way.
- Assembler for each valid byte:
  - 0xE0: set `ext`.
  - 0xF0: set `release`.
  - Any other byte: push {ext, release, byte} and clear both flags.
- Prefixes accumulate: the sequence E0 F0 xx yields ext=1, release=1.
- Push while FIFO full and no pop that cycle: event dropped, `overflow` pulses, flags cleared.
- Push and pop in the same cycle while full: allowed, occupancy unchanged.
- Timeout: counter ≠0 and no falling edge for `TIMEOUT_CYCLES` consecutive cycles → counter returns to 0. Prefix flags are kept; no error pulse.
- Output:
  - Pop on `key_valid && key_ready`.
  - `key_code`/`key_ext`/`key_release` always show the FIFO head and are don't-care when `key_valid`=0.
  - No bypass path around the FIFO.

## Timing
- All outputs reset to 0:
  - `key_valid`=0, `key_code`=0, `key_ext`=0, `key_release`=0, `overflow`=0, `frame_err`=0.
  - Bit counter, flags, FIFO pointers and timeout counter all reset to 0.
- Let E be the cycle in which the stop-bit falling edge is detected.
  - Push, `frame_err` and `overflow` are all registered and visible in E+1.
  - `key_valid` rises in E+1 when the FIFO was empty.
- Pop takes effect at the clock edge; the next head is visible the following cycle.
- `rst` asserted mid-frame or with the FIFO non-empty discards everything immediately (asynchronous reset). No event is emitted after release until a complete new frame arrives.
- Input-to-sample latency is `SYNC_STAGES`+1 cycles. A PS/2 clock of 10–16.7 kHz is assumed against a `clk` ≥1 MHz.

## Structure
- Package `ps2_pkg` holds:
  - `PS2_EXT_PREFIX`=8'hE0, `PS2_BRK_PREFIX`=8'hF0, `PS2_FRAME_BITS`=11.
  - Packed struct `ps2_event_t` {ext, release, code[7:0]}, 10 bits.
- Sub-module `sync_fifo`:
  - Parameterized width and depth; used with WIDTH=10, DEPTH=`FIFO_DEPTH`.
  - Ports: push/pop/full/empty/head.
  - Pointers one bit wider than the address.
- Frame receiver, assembler and timeout counter stay in the top module.

## Test plan
- Frame 0x1C, correct parity, `key_ready`=1 → one cycle with `key_valid`=1, code=0x1C, ext=0, release=0.
- Bytes F0 1C → single event code=0x1C, release=1. Bytes E0 F0 75 → code=0x75, ext=1, release=1. No event is produced for any prefix byte.
- Frame 0x1C with parity flipped → `frame_err` pulses once, no event. A following good 0x32 → code=0x32, flags 0.
- `key_ready`=0, send 9 codes 0x01..0x09 with DEPTH=8 → `overflow` pulses once, on 0x09. Draining yields 0x01..0x08 in order.
- Stop sending after 5 bits, idle > `TIMEOUT_CYCLES`, then send a full 0x2A → single event 0x2A, no `frame_err`.
- `rst` pulsed mid-frame with 3 events queued → `key_valid`=0 immediately. The next complete frame 0x3B yields exactly one event, 0x3B.
